// File: rtl/xy_route_ctrl.sv
// XY-routing input controller: one-entry holding register feeding a 1-to-5 demux, with packet FSM.
// Optional forwarded-packet statistics counter enabled by macro XY_ROUTE_STATS_EN.
module xy_route_ctrl #(
  parameter int FLIT_W  = 32,
  parameter int COORD_W = 2,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  output logic [2:0]        out_sel,
  input  logic [4:0]        out_ready,
  output logic              err,
  output logic [15:0]       pkt_count
);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

  typedef enum logic {IDLE, PKT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rdy_ext;
  logic        fire;
  logic        accept;
  logic        fwd;
  logic        drop;
  logic        load_sel;
  logic [1:0]  ftype;
  logic [2:0]  route;

  // X is resolved before Y; equal coordinates in both dimensions eject locally.
  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    if (dx > CX)      return 3'd2;
    else if (dx < CX) return 3'd4;
    else if (dy > CY) return 3'd1;
    else if (dy < CY) return 3'd3;
    else              return 3'd0;
  endfunction

  assign rdy_ext  = {3'b000, out_ready};
  assign fire     = out_valid & rdy_ext[out_sel];
  assign in_ready = ~rst & (~out_valid | fire);
  assign accept   = in_valid & in_ready;
  assign ftype    = in_flit[FLIT_W-1 -: 2];
  assign route    = xy_route(in_flit[COORD_W-1:0], in_flit[2*COORD_W-1:COORD_W]);

  always_comb begin
    state_d  = state_q;
    fwd      = 1'b0;
    drop     = 1'b0;
    load_sel = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (ftype == T_HEAD) begin
            fwd      = 1'b1;
            load_sel = 1'b1;
            state_d  = PKT;
          end else if (ftype == T_SINGLE) begin
            fwd      = 1'b1;
            load_sel = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
        PKT: begin
          if (ftype == T_BODY) begin
            fwd = 1'b1;
          end else if (ftype == T_TAIL) begin
            fwd     = 1'b1;
            state_d = IDLE;
          end else begin
            drop = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register stage: loads on forward, empties on fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_sel   <= 3'd0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      err     <= drop;
      if (fwd) begin
        out_flit  <= in_flit;
        out_valid <= 1'b1;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      if (load_sel) out_sel <= route;
    end
  end

`ifdef XY_ROUTE_STATS_EN
  logic [15:0] cnt_q;

  // Tail and single flits both have the top type bit set; each one firing closes a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (fire && out_flit[FLIT_W-1] && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign pkt_count = cnt_q;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_xy_route_ctrl.sv
// Bench for xy_route_ctrl at router (1,1): directed scenarios then random traffic vs a queue-based model.
module tb_xy_route_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_flit;
  logic        out_valid;
  logic [2:0]  out_sel;
  logic [4:0]  out_ready;
  logic        err;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  xy_route_ctrl #(.FLIT_W(32), .COORD_W(2), .CUR_X(1), .CUR_Y(1)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_sel(out_sel), .out_ready(out_ready),
    .err(err), .pkt_count(pkt_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: queue of pending forwarded flits with their ports.
  logic [31:0] q_flit[$];
  logic [2:0]  q_sel[$];
  bit          m_open = 0;
  logic [2:0]  m_sel = 0;
  bit          m_err = 0;
  int unsigned m_cnt = 0;
  bit          known = 0;

  function automatic logic [31:0] mk(input logic [1:0] t, input int dx, input int dy);
    logic [25:0] pay;
    pay = 26'($urandom);
    return {t, pay, 2'(dy), 2'(dx)};
  endfunction

  function automatic logic [2:0] ref_route(input logic [31:0] f);
    int dx, dy;
    dx = int'(f[1:0]);
    dy = int'(f[3:2]);
    if (dx > 1) return 3'd2;
    if (dx < 1) return 3'd4;
    if (dy > 1) return 3'd1;
    if (dy < 1) return 3'd3;
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [31:0] f, input logic [4:0] rdy);
    bit mfire, exp_rdy, acc;
    logic [1:0] t;
    logic [15:0] exp_cnt;
    rst = r; in_valid = v; in_flit = f; out_ready = rdy;
    #2;
    mfire = 0;
    if (q_flit.size() != 0) mfire = rdy[q_sel[0]];
    exp_rdy = !r && (q_flit.size() == 0 || mfire);
    chk("in_ready", in_ready, exp_rdy);
    if (known) begin
      chk("out_valid", out_valid, q_flit.size() != 0);
      if (q_flit.size() != 0) chk("out_flit", out_flit, q_flit[0]);
      chk("out_sel", out_sel, m_sel);
      chk("err", err, m_err);
`ifdef XY_ROUTE_STATS_EN
      exp_cnt = 16'(m_cnt);
`else
      exp_cnt = 16'd0;
`endif
      chk("pkt_count", pkt_count, exp_cnt);
    end
    if (r) begin
      q_flit.delete(); q_sel.delete();
      m_open = 0; m_sel = 0; m_err = 0; m_cnt = 0; known = 1;
    end else begin
      if (mfire) begin
        if (q_flit[0][31] && m_cnt < 65535) m_cnt++;
        void'(q_flit.pop_front()); void'(q_sel.pop_front());
      end
      acc = v && exp_rdy;
      m_err = 0;
      if (acc) begin
        t = f[31:30];
        if (!m_open) begin
          if (t == 2'b01 || t == 2'b11) begin
            m_sel = ref_route(f);
            q_flit.push_back(f); q_sel.push_back(m_sel);
            m_open = (t == 2'b01);
          end else m_err = 1;
        end else begin
          if (t == 2'b00 || t == 2'b10) begin
            q_flit.push_back(f); q_sel.push_back(m_sel);
            if (t == 2'b10) m_open = 0;
          end else m_err = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

  initial begin
    rst = 1; in_valid = 0; in_flit = 0; out_ready = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    // single to (3,1) goes east and fires next cycle
    cyc(0, 1, mk(S, 3, 1), 5'b00100);
    cyc(0, 0, 0, 5'b00100);
    cyc(0, 0, 0, 5'b00000);
    // local packet with two stalled cycles
    cyc(0, 1, mk(H, 1, 1), 5'b00000);
    cyc(0, 1, mk(B, 1, 1), 5'b00000);
    cyc(0, 1, mk(B, 1, 1), 5'b00000);
    cyc(0, 1, mk(B, 1, 1), 5'b00001);
    cyc(0, 1, mk(T, 1, 1), 5'b00001);
    cyc(0, 0, 0, 5'b00001);
    cyc(0, 0, 0, 5'b00001);
    // stray body in IDLE
    cyc(0, 1, mk(B, 2, 2), 5'b11111);
    cyc(0, 0, 0, 5'b11111);
    cyc(0, 0, 0, 5'b11111);
    // tail fire overlapping next head toward west
    cyc(0, 1, mk(H, 3, 3), 5'b00100);
    cyc(0, 1, mk(T, 0, 0), 5'b00100);
    cyc(0, 1, mk(H, 0, 1), 5'b00100);
    cyc(0, 1, mk(T, 0, 0), 5'b10000);
    cyc(0, 0, 0, 5'b10000);
    cyc(0, 0, 0, 5'b10000);
    // reset mid-packet, then orphan body
    cyc(0, 1, mk(H, 1, 3), 5'b00000);
    cyc(1, 0, 0, 5'b00000);
    cyc(0, 1, mk(B, 1, 3), 5'b11111);
    cyc(0, 0, 0, 5'b11111);
    cyc(0, 0, 0, 5'b11111);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      int k;
      logic [1:0] ty;
      k = int'($urandom_range(0, 99));
      ty = (k < 25) ? H : (k < 60) ? B : (k < 85) ? T : S;
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          mk(ty, int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
          5'($urandom));
    end
    cyc(0, 0, 0, 5'b11111);
    cyc(0, 0, 0, 5'b11111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
